fifo_wptr_gray: RTL and testbench
=================================

# fifo_wptr_gray

Write-side pointer and flag controller for the team's asynchronous FIFOs. It sits in the write clock domain. It generates the RAM write address and a registered Gray-coded write pointer for transfer to the read domain through `gray_sync`. It also decodes the already-synchronized Gray read pointer and produces full, almost-full, occupancy and overflow status. It is the transmitting end of the Gray-pointer crossing whose receiving end is `gray_sync`.

## Interface
- `ADDR_WIDTH`, default 4: FIFO depth is 2^ADDR_WIDTH. Pointers are ADDR_WIDTH+1 bits. Legal range is ≥ 2.
- `AFULL_THRESH`, default 2^ADDR_WIDTH−2: `almost_full` is asserted when occupancy ≥ this value. Legal range is 1..2^ADDR_WIDTH.
- `clk`, in, 1: write-domain clock. Everything is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `wr_en`, in, 1: write request.
- `wr_ack`, out, 1: combinational; `wr_en & ~full & ~reset`. When high, the RAM write at `waddr` happens this cycle.
- `waddr`, out, ADDR_WIDTH: RAM write address, equal to `wbin[ADDR_WIDTH-1:0]`.
- `wptr_gray`, out, ADDR_WIDTH+1: registered Gray write pointer. This is the only signal that may cross to the read domain.
- `rptr_gray_sync`, in, ADDR_WIDTH+1: Gray read pointer, already synchronized into `clk`.
- `full`, out, 1: registered.
- `almost_full`, out, 1: registered.
- `wr_level`, out, ADDR_WIDTH+1: registered, conservative occupancy from 0 to 2^ADDR_WIDTH.
- `overflow`, out, 1: sticky. Set by a write attempt while full; cleared only by `reset`.

## Operation
- Internal state:
  - `wbin`: ADDR_WIDTH+1-bit binary pointer.
  - Registers for `wptr_gray`, `full`, `almost_full`, `wr_level` and `overflow`.
- Next-state arithmetic:
  - `wbin_next = wbin + wr_ack`, modulo 2^(ADDR_WIDTH+1).
  - `wgray_next = wbin_next ^ (wbin_next >> 1)`.
- Read pointer decode: `rbin` is the Gray-to-binary decode of `rptr_gray_sync`, where `rbin[i] = ^rptr_gray_sync[ADDR_WIDTH:i]`.
- Full: `full_next = (wgray_next == {~rptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1], rptr_gray_sync[ADDR_WIDTH-2:0]})`.
- Level: `level_next = wbin_next − rbin`, modulo 2^(ADDR_WIDTH+1).
- Almost full: `almost_full_next = (level_next >= AFULL_THRESH)`.
- Overflow: `overflow_next = overflow | (wr_en & full)`.
- All of the above `_next` values are registered every cycle.
- `wptr_gray` is driven directly from a flop, never from logic, so it is glitch-free for the crossing.
- `rptr_gray_sync` is assumed to change by at most one bit per `clk` cycle. That is guaranteed by the read side plus `gray_sync`.
- Pointer wrap: `wbin` goes from 2^(ADDR_WIDTH+1)−1 to 0. `wptr_gray` goes from {1,0…0} to 0, a single-bit change. Level and full remain correct across the wrap through the modular arithmetic.
- No state machine beyond the pointer: the block is a pure pointer/flag pipeline.

## Timing
- Reset: on the edge where `reset` is high, the following are all 0 on the next cycle, regardless of `wr_en`:
  - `wbin`, `wptr_gray`, `full`, `almost_full`, `wr_level`, `overflow`.
- While `reset` is high, `wr_ack` is 0.
- Resetting mid-operation discards the pointer. The read side must be reset coherently; that is the system's responsibility.
- Write latency:
  - A write acked in cycle N is reflected in `waddr`, `wptr_gray`, `wr_level`, `full` and `almost_full` in cycle N+1.
  - `full` asserts in the cycle immediately after the accepted write that fills the FIFO, so a write is never acked while the FIFO is full.
- Read-side change: a change on `rptr_gray_sync` in cycle N updates `full`, `almost_full` and `wr_level` in cycle N+1.
- Simultaneous write request and read-pointer release while `full`=1:
  - The write is rejected in cycle N, because `full` is still 1.
  - `full` drops in N+1 and a write can be acked in N+1.
- Overflow: `overflow` rises in the cycle after the first write attempt while full.
- Conservatism: the synchronizer delay means `full` and `wr_level` can overstate occupancy, but never understate it.

## Test plan
All scenarios use ADDR_WIDTH=4 and AFULL_THRESH=14.
1. **Fill:** reset, then hold `rptr_gray_sync`=0 and apply 16 consecutive `wr_en`.
   - `waddr` steps 0..15 and `wptr_gray` steps 0,1,3,2,6,7,5,4,12,…
   - `almost_full`=1 the cycle after the 14th write.
   - After the 16th write: `full`=1, `wr_level`=16, `wptr_gray`=5'b11000.
2. **Overflow:** from full, apply `wr_en`=1 for one cycle.
   - `wr_ack`=0; `waddr` and `wptr_gray` unchanged.
   - `overflow`=1 the next cycle and stays 1 until reset.
3. **Release:** from full, set `rptr_gray_sync`=5'b00001.
   - Next cycle: `full`=0, `wr_level`=15.
   - A following write is acked at `waddr`=0 and `full` returns to 1.
4. **Wrap:** stream writes with `rptr_gray_sync` trailing by 4 entries.
   - `wptr_gray` goes 5'b10000 → 5'b00000 at the wrap.
   - With `wbin`=2 and `rbin`=30, `wr_level`=4.
   - `full` never asserts.
5. **Simultaneous:** at full, raise `wr_en` and change `rptr_gray_sync` to free one entry in the same cycle.
   - `wr_ack`=0 that cycle.
   - `wr_ack`=1 the next cycle.
6. **Reset mid-operation:** at `wr_level`=9, assert `reset` with `wr_en`=1.
   - `wr_ack`=0 during reset.
   - All outputs are 0 the cycle after reset.

Source files
------------

// File: rtl/fifo_wptr_gray.sv
// rtl/fifo_wptr_gray.sv - write-side Gray pointer and flag controller for async FIFOs
//
// Purpose: lives in the write clock domain of an asynchronous FIFO. Keeps the
// binary write pointer and produces the RAM write address. Produces a registered
// Gray-coded write pointer for the crossing to the read domain. Decodes the
// synchronized Gray read pointer into full, almost-full, occupancy and a sticky
// overflow flag.
//
// Ports:
//   clk            in   write-domain clock, rising edge
//   reset          in   synchronous, active-high
//   wr_en          in   write request
//   wr_ack         out  write accepted this cycle (combinational)
//   waddr          out  RAM write address
//   wptr_gray      out  registered Gray write pointer (crosses to read domain)
//   rptr_gray_sync in   Gray read pointer, already synchronized into clk
//   full           out  registered full flag
//   almost_full    out  registered, occupancy >= AFULL_THRESH
//   wr_level       out  registered, conservative occupancy 0..2^ADDR_WIDTH
//   overflow       out  sticky, set by a write attempt while full

module fifo_wptr_gray #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;

  // Threshold narrowed to pointer width; legal values (<= 2^ADDR_WIDTH) fit.
  localparam logic [PW-1:0] AFULL_LVL = AFULL_THRESH[PW-1:0];

  // Full means the write pointer is exactly one lap ahead of the read pointer.
  // In Gray code that is the read pointer with its two MSBs inverted.
  localparam logic [PW-1:0] FULL_MASK = {2'b11, {(PW - 2){1'b0}}};

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_next;
  logic          full_next;
  logic          almost_full_next;
  logic          overflow_next;

  assign wr_ack = wr_en & ~full & ~reset;
  assign waddr  = wbin[ADDR_WIDTH-1:0];

  always_comb begin
    wbin_next  = wbin + PW'(wr_ack);
    wgray_next = wbin_next ^ (wbin_next >> 1);
  end

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(rptr_gray_sync >> i);
    end
  end

  always_comb begin
    full_next        = (wgray_next == (rptr_gray_sync ^ FULL_MASK));
    // Modular subtraction keeps the level correct across pointer wrap.
    level_next       = wbin_next - rbin;
    almost_full_next = (level_next >= AFULL_LVL);
    overflow_next    = overflow | (wr_en & full);
  end

  // wptr_gray comes straight from a flop so the crossing never sees a glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      wbin        <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wptr_gray   <= wgray_next;
      full        <= full_next;
      almost_full <= almost_full_next;
      wr_level    <= level_next;
      overflow    <= overflow_next;
    end
  end

endmodule

// File: tb/tb_fifo_wptr_gray.sv
// tb/tb_fifo_wptr_gray.sv - self-checking bench for fifo_wptr_gray

module tb_fifo_wptr_gray;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int THR   = 14;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic          wr_ack;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr_gray;
  logic [AW:0]   rptr_gray_sync = '0;
  logic          full;
  logic          almost_full;
  logic [AW:0]   wr_level;
  logic          overflow;

  fifo_wptr_gray #(.ADDR_WIDTH(AW), .AFULL_THRESH(THR)) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_ack         (wr_ack),
    .waddr          (waddr),
    .wptr_gray      (wptr_gray),
    .rptr_gray_sync (rptr_gray_sync),
    .full           (full),
    .almost_full    (almost_full),
    .wr_level       (wr_level),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: total entries written / read as plain counts.
  int m_w = 0;
  int m_r = 0;
  int m_level = 0;
  bit m_full = 0;
  bit m_afull = 0;
  bit m_ovf = 0;
  logic last_ack;

  function automatic logic [AW:0] to_gray(input int v);
    logic [AW:0] b;
    b = v[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the combinational ack, clock,
  // advance the model, then check all registered outputs.
  task automatic cycle(input bit wr, input bit rst, input int r);
    bit exp_ack;
    wr_en          = wr;
    reset          = rst;
    rptr_gray_sync = to_gray(r);
    #1;
    exp_ack  = wr && !m_full && !rst;
    last_ack = wr_ack;
    chk("wr_ack", {31'd0, wr_ack}, {31'd0, exp_ack});
    @(posedge clk);
    if (rst) begin
      m_w = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
    end else begin
      if (wr && m_full) m_ovf = 1;
      if (exp_ack) m_w++;
      m_level = m_w - r;
      m_full  = (m_level == DEPTH);
      m_afull = (m_level >= THR);
    end
    m_r = r;
    #1;
    chk("waddr",       {28'd0, waddr},       m_w % DEPTH);
    chk("wptr_gray",   {27'd0, wptr_gray},   {27'd0, to_gray(m_w)});
    chk("full",        {31'd0, full},        {31'd0, m_full});
    chk("almost_full", {31'd0, almost_full}, {31'd0, m_afull});
    chk("wr_level",    {27'd0, wr_level},    m_level);
    chk("overflow",    {31'd0, overflow},    {31'd0, m_ovf});
    @(negedge clk);
  endtask

  logic [AW:0] gray_seq [9];

  initial begin
    gray_seq = '{5'd0, 5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4, 5'd12};

    // Reset
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    chk("reset_level", {27'd0, wr_level}, 0);
    chk("reset_full", {31'd0, full}, 0);

    // 1. Fill
    for (int i = 0; i < 16; i++) begin
      chk("fill_waddr", {28'd0, waddr}, i);
      if (i < 9) chk("fill_gray_seq", {27'd0, wptr_gray}, {27'd0, gray_seq[i]});
      cycle(1, 0, 0);
      if (i == 12) chk("afull_before_14", {31'd0, almost_full}, 0);
      if (i == 13) chk("afull_after_14", {31'd0, almost_full}, 1);
    end
    chk("fill_full", {31'd0, full}, 1);
    chk("fill_level", {27'd0, wr_level}, 16);
    chk("fill_gray", {27'd0, wptr_gray}, 32'h18);

    // 2. Overflow
    cycle(1, 0, 0);
    chk("ovf_ack", {31'd0, last_ack}, 0);
    chk("ovf_set", {31'd0, overflow}, 1);
    chk("ovf_waddr", {28'd0, waddr}, 0);
    chk("ovf_gray", {27'd0, wptr_gray}, 32'h18);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("ovf_sticky", {31'd0, overflow}, 1);

    // 3. Release one entry
    cycle(0, 0, 1);
    chk("rel_full", {31'd0, full}, 0);
    chk("rel_level", {27'd0, wr_level}, 15);
    chk("rel_waddr", {28'd0, waddr}, 0);
    cycle(1, 0, 1);
    chk("rel_ack", {31'd0, last_ack}, 1);
    chk("rel_full_again", {31'd0, full}, 1);

    // 5. Simultaneous write request and release while full
    cycle(1, 0, 2);
    chk("sim_ack0", {31'd0, last_ack}, 0);
    cycle(1, 0, 2);
    chk("sim_ack1", {31'd0, last_ack}, 1);

    // 4. Wrap with read pointer trailing by 4
    while (m_r < m_w - 4) cycle(0, 0, m_r + 1);
    while (m_w < 34) begin
      cycle(1, 0, m_r + 1);
      chk("wrap_no_full", {31'd0, full}, 0);
      if (m_w == 31) chk("wrap_gray_top", {27'd0, wptr_gray}, 32'h10);
      if (m_w == 32) chk("wrap_gray_zero", {27'd0, wptr_gray}, 0);
    end
    chk("wrap_level", {27'd0, wr_level}, 4);

    // 6. Reset mid-operation at level 9
    repeat (5) cycle(1, 0, m_r);
    chk("pre_rst_level", {27'd0, wr_level}, 9);
    cycle(1, 1, 0);
    chk("rst_ack", {31'd0, last_ack}, 0);
    chk("rst_waddr", {28'd0, waddr}, 0);
    chk("rst_gray", {27'd0, wptr_gray}, 0);
    chk("rst_level", {27'd0, wr_level}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    chk("rst_afull", {31'd0, almost_full}, 0);

    // Randomized traffic: write-heavy then read-heavy phases
    for (int i = 0; i < 600; i++) begin
      bit wr;
      int r;
      if (i < 300) begin
        wr = ($urandom_range(0, 3) != 0);
        r  = (m_r < m_w && $urandom_range(0, 3) == 0) ? m_r + 1 : m_r;
      end else begin
        wr = ($urandom_range(0, 3) == 0);
        r  = (m_r < m_w && $urandom_range(0, 3) != 0) ? m_r + 1 : m_r;
      end
      cycle(wr, 0, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
